debounce: RTL and testbench
===========================

DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset named rst; clock port is clk.
REQ-002 Parameters (name, default, meaning), one per line:
- SYNC_STAGES, 2, number of flip-flops in the button synchronizer; minimum 2.
- STABLE_CYCLES, 100, consecutive clk cycles a new level must persist before result follows; minimum 1.
- CNT_WIDTH, 7, stability counter width; must satisfy 2^CNT_WIDTH > STABLE_CYCLES-1.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- button, input, 1, raw asynchronous push-button level, may bounce.
- result, output, 1, debounced button level, driven directly from a flip-flop.

Function
REQ-004 button SHALL pass through a SYNC_STAGES-deep flip-flop chain; the last stage is sync_out, and no other logic samples button.
REQ-005 A stability counter SHALL update on every rising clk edge:
- sync_out == result: counter cleared to 0.
- sync_out != result and counter == STABLE_CYCLES-1: result <= sync_out, counter cleared to 0.
- otherwise: counter incremented by 1.
REQ-006 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-007 The control SHALL be a 4-state FSM encoded as 2 bits:
- STABLE_LOW: result=0.
- PEND_HIGH: result=0, counting.
- STABLE_HIGH: result=1.
- PEND_LOW: result=1, counting.
REQ-008 FSM transitions:
- STABLE_LOW -> PEND_HIGH when sync_out=1.
- PEND_HIGH -> STABLE_LOW when sync_out=0 (glitch rejected).
- PEND_HIGH -> STABLE_HIGH at the terminal count.
- The STABLE_HIGH / PEND_LOW pair behaves symmetrically.
REQ-009 Latency: if button is first sampled at its new level at edge E0 and stays stable, result SHALL change on edge E0+SYNC_STAGES+STABLE_CYCLES-1 (edge 101 with defaults).
REQ-010 Any return of sync_out to the current result level during counting SHALL restart the full count; pulses shorter than STABLE_CYCLES synchronized cycles SHALL never reach result.
REQ-011 result SHALL toggle at most once per STABLE_CYCLES cycles.
REQ-012 result SHALL be glitch-free and change only on a rising clk edge or on reset assertion.
REQ-013 An X or unknown value on button SHALL NOT propagate to result while rst=0.

Reset
REQ-014 While rst=0, all of the following SHALL hold asynchronously, independent of clk:
- synchronizer flops = 0;
- counter = 0;
- FSM = STABLE_LOW;
- result = 0.
REQ-015 Reset asserted mid-count SHALL abort the pending transition.
REQ-016 After rst deasserts, the block SHALL run from the reset values on the next rising clk edge.
REQ-017 If button=1 at reset release, result SHALL rise only after the full latency of REQ-009.

Verification
Common setup: clk period 20 ns, default parameters.
REQ-018 rst=0 for 200 ns with button=X -> result=0 throughout; after release with button=0, result stays 0.
REQ-019 button rises, bounces 0 for 800 ns and 1 for 800 ns, then holds 1 for 40 us -> result rises exactly 101 edges after the final 0->1 sample and never pulses during the bounce.
REQ-020 button=1 is stable, then falls for 400 ns (20 cycles) -> result remains 1.
REQ-021 With result=1, button held 0 for 4 us (200 cycles) -> result falls after 101 edges and rises again 101 edges after button returns to 1.
REQ-022 A pulse of exactly STABLE_CYCLES-1 synchronized cycles -> no change; a pulse of exactly STABLE_CYCLES cycles -> result toggles.
REQ-023 rst asserted at count 50 of a pending rise -> result=0 and counter=0 immediately; after release, a fresh 101-edge count is required.

Source files
------------

// File: rtl/debounce.sv
// Push-button debouncer: a synchronizer chain feeding a four-state FSM that holds
// result until the synchronized level has differed from it for STABLE_CYCLES clocks.
module debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 100,
    parameter int CNT_WIDTH     = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic result
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        PEND_LOW    = 2'b10,
        STABLE_HIGH = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   result_d;
    logic                   terminal;

    // Only this chain ever looks at the raw button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign terminal = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            result  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            result  <= result_d;
        end
    end

    // The stable states always hold a zero count, so "terminal" there only
    // fires when STABLE_CYCLES is 1 and the level must be taken at once.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result;
        case (state_q)
            STABLE_LOW: begin
                cnt_d = '0;
                if (sync_out) begin
                    if (terminal) begin
                        state_d  = STABLE_HIGH;
                        result_d = 1'b1;
                    end else begin
                        state_d = PEND_HIGH;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            PEND_HIGH: begin
                if (!sync_out) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (terminal) begin
                    state_d  = STABLE_HIGH;
                    cnt_d    = '0;
                    result_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HIGH: begin
                cnt_d = '0;
                if (!sync_out) begin
                    if (terminal) begin
                        state_d  = STABLE_LOW;
                        result_d = 1'b0;
                    end else begin
                        state_d = PEND_LOW;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            PEND_LOW: begin
                if (sync_out) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (terminal) begin
                    state_d  = STABLE_LOW;
                    cnt_d    = '0;
                    result_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = STABLE_LOW;
                cnt_d    = '0;
                result_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: the driver queues each expected result transition with the
// edge it must land on; a monitor pops and checks whenever result changes.
module tb_debounce;

    logic clk = 1'b0;
    logic rst;
    logic button;
    logic result;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    logic [31:0] exp_q[$];

    always #10 clk = ~clk;

    debounce dut (
        .clk(clk),
        .rst(rst),
        .button(button),
        .result(result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_edge(input logic v, input int e);
        exp_q.push_back({v, 31'(e)});
    endtask

    // Called at a negedge; button is first sampled on edge start+1.
    task automatic set_button(input logic lvl, output int start);
        button = lvl;
        start = edge_cnt;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every change of result must match the head of the queue.
    initial begin
        logic prev;
        logic [31:0] e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            if (result !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: result=%0b at edge %0d, required no change",
                             result, edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (result !== e[31] || 32'(edge_cnt) != {1'b0, e[30:0]}) begin
                        bad++;
                        $display("FAIL transition: result=%0b at edge %0d, required %0b at edge %0d",
                                 result, edge_cnt, e[31], e[30:0]);
                    end
                end
                prev = result;
            end
        end
    end

    initial begin
        int s;
        rst = 1'b1;
        button = 1'bx;
        #1 rst = 1'b0;

        // Held in reset with an unknown button.
        repeat (10) begin
            @(negedge clk);
            check("reset_result", 32'(result), 32'd0);
        end
        check("reset_cnt", 32'(dut.cnt_q), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'd0);

        button = 1'b0;
        rst = 1'b1;
        wait_cycles(150);

        // Bouncing rise, then a long stable high.
        set_button(1'b1, s); wait_cycles(40);
        set_button(1'b0, s); wait_cycles(40);
        set_button(1'b1, s);
        expect_edge(1'b1, s + 102);
        wait_cycles(2000);

        // Short low glitch is rejected.
        set_button(1'b0, s); wait_cycles(20);
        set_button(1'b1, s); wait_cycles(150);

        // Long low then long high.
        set_button(1'b0, s);
        expect_edge(1'b0, s + 102);
        wait_cycles(200);
        set_button(1'b1, s);
        expect_edge(1'b1, s + 102);
        wait_cycles(200);

        // Pulse one cycle too short, then exactly long enough.
        set_button(1'b0, s); wait_cycles(99);
        set_button(1'b1, s); wait_cycles(150);
        set_button(1'b0, s);
        expect_edge(1'b0, s + 102);
        wait_cycles(100);
        set_button(1'b1, s);
        expect_edge(1'b1, s + 102);
        wait_cycles(150);

        // Return low, then abort a pending rise with reset at count 50.
        set_button(1'b0, s);
        expect_edge(1'b0, s + 102);
        wait_cycles(200);
        set_button(1'b1, s);
        wait_cycles(52);
        check("mid_cnt", 32'(dut.cnt_q), 32'd50);
        check("mid_state", 32'(dut.state_q), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_cnt", 32'(dut.cnt_q), 32'd0);
        check("abort_state", 32'(dut.state_q), 32'd0);
        check("abort_sync", 32'(dut.sync_q), 32'd0);
        wait_cycles(5);
        rst = 1'b1;
        s = edge_cnt;
        expect_edge(1'b1, s + 102);
        wait_cycles(200);

        wait_cycles(10);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_transitions: got %0d pending, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
